// File: rtl/v_pkg.sv
// Shared list-update types: product/command fields, the issue FIFO entry,
// and the depth of the downstream read-modify-write pipeline.
package v_pkg;

    typedef logic [7:0]  id_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_MOD = 2'd1,
        CMD_DEL = 2'd2,
        CMD_CLR = 2'd3
    } cmd_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_cmd_t;

    localparam int unsigned UPD_PIPE_STAGES = 4;

endpackage

// File: rtl/v_upd_issue_fifo.sv
// In-order DEPTH-entry FIFO of update commands; storage is not reset, only
// pointers and count. Push is ignored when full, pop when empty.
module v_upd_issue_fifo
    import v_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  upd_cmd_t                 push_data,
    input  logic                     pop,
    output upd_cmd_t                 head,
    output logic [$clog2(DEPTH):0]   count_nxt,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    upd_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_r;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count_r;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_r + CNT_ONE;
            2'b01:   count_nxt = count_r - CNT_ONE;
            default: count_nxt = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count_r <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/v_upd_issue.sv
// Issue stage feeding the list-update pipeline: buffers commands in order and
// holds the head while its prod_id is in flight. Optional V_UPD_ISSUE_STATS_EN.
module v_upd_issue
    import v_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_cmd_vld,
    input  id_t   i_cmd_prod_id,
    input  cmd_t  i_cmd_cmd,
    input  key_t  i_cmd_key,
    input  size_t i_cmd_size,
    output logic  o_cmd_rdy,
    input  logic  i_s1_upd_vld_r,
    input  id_t   i_s1_upd_prod_id_r,
    input  logic  i_s2_upd_vld_r,
    input  id_t   i_s2_upd_prod_id_r,
    input  logic  i_s3_upd_vld_r,
    input  id_t   i_s3_upd_prod_id_r,
    input  logic  i_s4_upd_vld_r,
    input  id_t   i_s4_upd_prod_id_r,
    output logic  o_upd_vld_r,
    output id_t   o_upd_prod_id_r,
    output cmd_t  o_upd_cmd_r,
    output key_t  o_upd_key_r,
    output size_t o_upd_size_r,
    output logic  o_busy_r
`ifdef V_UPD_ISSUE_STATS_EN
    ,
    output logic [31:0] o_stat_issued_r,
    output logic [31:0] o_stat_stall_r,
    output logic [31:0] o_stat_full_r
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    upd_cmd_t                 push_data;
    upd_cmd_t                 head;
    logic [PTR_W:0]           count_nxt;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     issue;
    logic                     hazard;
    logic [UPD_PIPE_STAGES:0] inflight_vld;
    id_t                      inflight_id [UPD_PIPE_STAGES+1];

    assign o_cmd_rdy = !full;
    assign push      = i_cmd_vld && o_cmd_rdy;
    assign push_data = '{prod_id: i_cmd_prod_id, cmd: i_cmd_cmd,
                         key: i_cmd_key, size: i_cmd_size};

    v_upd_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .head      (head),
        .count_nxt (count_nxt),
        .full      (full),
        .empty     (empty)
    );

    // Slot 0 is our own issue register; slots 1..4 are pipeline stages S1..S4.
    always_comb begin
        inflight_vld   = {i_s4_upd_vld_r, i_s3_upd_vld_r, i_s2_upd_vld_r,
                          i_s1_upd_vld_r, o_upd_vld_r};
        inflight_id[0] = o_upd_prod_id_r;
        inflight_id[1] = i_s1_upd_prod_id_r;
        inflight_id[2] = i_s2_upd_prod_id_r;
        inflight_id[3] = i_s3_upd_prod_id_r;
        inflight_id[4] = i_s4_upd_prod_id_r;
        hazard = 1'b0;
        for (int unsigned i = 0; i <= UPD_PIPE_STAGES; i++) begin
            if (inflight_vld[i] && (inflight_id[i] == head.prod_id)) hazard = 1'b1;
        end
    end

    assign issue = !empty && !hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_upd_vld_r <= 1'b0;
            o_busy_r    <= 1'b0;
        end else begin
            o_upd_vld_r <= issue;
            o_busy_r    <= (count_nxt != '0) || issue;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            o_upd_prod_id_r <= head.prod_id;
            o_upd_cmd_r     <= head.cmd;
            o_upd_key_r     <= head.key;
            o_upd_size_r    <= head.size;
        end
    end

`ifdef V_UPD_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_issued_r <= '0;
            o_stat_stall_r  <= '0;
            o_stat_full_r   <= '0;
        end else begin
            if (issue)                o_stat_issued_r <= o_stat_issued_r + 32'd1;
            if (!empty && hazard)     o_stat_stall_r  <= o_stat_stall_r + 32'd1;
            if (i_cmd_vld && !o_cmd_rdy) o_stat_full_r <= o_stat_full_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_v_upd_issue.sv
// Scoreboard bench for v_upd_issue: expected issues (data + cycle) are queued
// by the stimulus; a monitor pops and compares whenever o_upd_vld_r is seen.
module tb_v_upd_issue;
    import v_pkg::*;

    typedef struct {
        upd_cmd_t    d;
        int unsigned at;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  i_cmd_vld = 1'b0;
    id_t   i_cmd_prod_id = '0;
    cmd_t  i_cmd_cmd = CMD_ADD;
    key_t  i_cmd_key = '0;
    size_t i_cmd_size = '0;
    logic  o_cmd_rdy;
    logic  o_upd_vld_r;
    id_t   o_upd_prod_id_r;
    cmd_t  o_upd_cmd_r;
    key_t  o_upd_key_r;
    size_t o_upd_size_r;
    logic  o_busy_r;
`ifdef V_UPD_ISSUE_STATS_EN
    logic [31:0] o_stat_issued_r, o_stat_stall_r, o_stat_full_r;
    logic [31:0] snap_issued, snap_stall, snap_full;
`endif

    // Downstream pipeline model (pm_*) plus directed per-stage overrides (ov_*).
    logic [4:1] pm_vld = '0;
    id_t        pm_id [1:4] = '{default: '0};
    logic [4:1] ov_vld = '0;
    id_t        ov_id [1:4] = '{default: '0};
    logic       prev_vld = 1'b0;
    id_t        prev_id = '0;

    exp_t        sb [$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    v_upd_issue #(
        .DEPTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_cmd_vld          (i_cmd_vld),
        .i_cmd_prod_id      (i_cmd_prod_id),
        .i_cmd_cmd          (i_cmd_cmd),
        .i_cmd_key          (i_cmd_key),
        .i_cmd_size         (i_cmd_size),
        .o_cmd_rdy          (o_cmd_rdy),
        .i_s1_upd_vld_r     (pm_vld[1] | ov_vld[1]),
        .i_s1_upd_prod_id_r (ov_vld[1] ? ov_id[1] : pm_id[1]),
        .i_s2_upd_vld_r     (pm_vld[2] | ov_vld[2]),
        .i_s2_upd_prod_id_r (ov_vld[2] ? ov_id[2] : pm_id[2]),
        .i_s3_upd_vld_r     (pm_vld[3] | ov_vld[3]),
        .i_s3_upd_prod_id_r (ov_vld[3] ? ov_id[3] : pm_id[3]),
        .i_s4_upd_vld_r     (pm_vld[4] | ov_vld[4]),
        .i_s4_upd_prod_id_r (ov_vld[4] ? ov_id[4] : pm_id[4]),
        .o_upd_vld_r        (o_upd_vld_r),
        .o_upd_prod_id_r    (o_upd_prod_id_r),
        .o_upd_cmd_r        (o_upd_cmd_r),
        .o_upd_key_r        (o_upd_key_r),
        .o_upd_size_r       (o_upd_size_r),
        .o_busy_r           (o_busy_r)
`ifdef V_UPD_ISSUE_STATS_EN
        ,
        .o_stat_issued_r    (o_stat_issued_r),
        .o_stat_stall_r     (o_stat_stall_r),
        .o_stat_full_r      (o_stat_full_r)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d n_fail=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic key_t key_of(input id_t id);
        return {8'hA5, id};
    endfunction

    function automatic size_t size_of(input id_t id);
        return {8'h00, id} + 16'd3;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void expect_issue(input id_t id, input cmd_t c, input int unsigned at);
        exp_t e;
        e.d  = '{prod_id: id, cmd: c, key: key_of(id), size: size_of(id)};
        e.at = at;
        sb.push_back(e);
    endfunction

    task automatic push(input id_t id, input cmd_t c);
        i_cmd_vld     = 1'b1;
        i_cmd_prod_id = id;
        i_cmd_cmd     = c;
        i_cmd_key     = key_of(id);
        i_cmd_size    = size_of(id);
        @(negedge clk);
        i_cmd_vld     = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // S1 takes what the issue register held one cycle earlier; S2..S4 shift on.
    initial forever begin
        @(negedge clk);
        for (int n = 4; n > 1; n--) begin
            pm_vld[n] = pm_vld[n-1];
            pm_id[n]  = pm_id[n-1];
        end
        pm_vld[1] = prev_vld;
        pm_id[1]  = prev_id;
        prev_vld  = (o_upd_vld_r === 1'b1);
        prev_id   = o_upd_prod_id_r;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (o_upd_vld_r === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_issue: actual issue of id %0d at cycle %0d, required no issue",
                         o_upd_prod_id_r, cyc);
            end else begin
                e = sb.pop_front();
                check("issue_prod_id", 64'(o_upd_prod_id_r), 64'(e.d.prod_id));
                check("issue_cmd_key_size", 64'({o_upd_cmd_r, o_upd_key_r, o_upd_size_r}),
                      64'({e.d.cmd, e.d.key, e.d.size}));
                check("issue_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        int unsigned p;
        int unsigned d;

        // reset state
        idle(3);
        check("reset_vld", 64'(o_upd_vld_r), 64'd0);
        check("reset_busy", 64'(o_busy_r), 64'd0);
        check("reset_rdy", 64'(o_cmd_rdy), 64'd1);
        rst = 1'b0;
        idle(8);

        // three distinct ids back to back, each issues one edge after its push
        p = cyc + 1;
        expect_issue(8'd1, CMD_ADD, p + 1);
        expect_issue(8'd2, CMD_MOD, p + 2);
        expect_issue(8'd3, CMD_DEL, p + 3);
        push(8'd1, CMD_ADD);
        check("busy_after_push", 64'(o_busy_r), 64'd1);
        push(8'd2, CMD_MOD);
        push(8'd3, CMD_DEL);
        idle(10);
        check("busy_idle", 64'(o_busy_r), 64'd0);

        // same id twice: second waits for issue reg + S1..S4 to drain
`ifdef V_UPD_ISSUE_STATS_EN
        snap_issued = o_stat_issued_r;
        snap_stall  = o_stat_stall_r;
`endif
        p = cyc + 1;
        expect_issue(8'd5, CMD_ADD, p + 1);
        expect_issue(8'd5, CMD_DEL, p + 7);
        push(8'd5, CMD_ADD);
        push(8'd5, CMD_DEL);
        idle(12);
`ifdef V_UPD_ISSUE_STATS_EN
        check("stat_issued_delta", 64'(o_stat_issued_r - snap_issued), 64'd2);
        check("stat_stall_delta", 64'(o_stat_stall_r - snap_stall), 64'd5);
`endif

        // S3 holds id 7: 7 blocked, and 9 blocked behind it
        ov_vld[3] = 1'b1;
        ov_id[3]  = 8'd7;
        push(8'd7, CMD_MOD);
        push(8'd9, CMD_ADD);
        idle(5);
        check("blocked_busy", 64'(o_busy_r), 64'd1);
        check("blocked_rdy", 64'(o_cmd_rdy), 64'd1);
        d = cyc + 1;
        expect_issue(8'd7, CMD_MOD, d);
        expect_issue(8'd9, CMD_ADD, d + 1);
        ov_vld[3] = 1'b0;
        idle(10);

        // fill all 8 entries behind a blocked head, then try a 9th
`ifdef V_UPD_ISSUE_STATS_EN
        snap_full = o_stat_full_r;
`endif
        ov_vld[1] = 1'b1;
        ov_id[1]  = 8'd2;
        push(8'd2, CMD_CLR);
        for (int i = 0; i < 7; i++) begin
            check("rdy_while_filling", 64'(o_cmd_rdy), 64'd1);
            push(id_t'(10 + i), CMD_ADD);
        end
        check("full_rdy_low", 64'(o_cmd_rdy), 64'd0);
        push(8'd99, CMD_DEL);
        check("refused_rdy_low", 64'(o_cmd_rdy), 64'd0);
        check("refused_busy", 64'(o_busy_r), 64'd1);
        d = cyc + 1;
        expect_issue(8'd2, CMD_CLR, d);
        for (int i = 0; i < 7; i++) expect_issue(id_t'(10 + i), CMD_ADD, d + 1 + i);
        ov_vld[1] = 1'b0;
        @(negedge clk);
        check("rdy_after_first_issue", 64'(o_cmd_rdy), 64'd1);
        idle(12);
`ifdef V_UPD_ISSUE_STATS_EN
        check("stat_full_delta", 64'(o_stat_full_r - snap_full), 64'd1);
`endif

        // reset while the fourth entry is about to issue
        p = cyc + 1;
        expect_issue(8'd20, CMD_ADD, p + 1);
        expect_issue(8'd21, CMD_MOD, p + 2);
        expect_issue(8'd22, CMD_DEL, p + 3);
        push(8'd20, CMD_ADD);
        push(8'd21, CMD_MOD);
        push(8'd22, CMD_DEL);
        push(8'd23, CMD_CLR);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_vld", 64'(o_upd_vld_r), 64'd0);
        check("midrst_busy", 64'(o_busy_r), 64'd0);
        check("midrst_rdy", 64'(o_cmd_rdy), 64'd1);
`ifdef V_UPD_ISSUE_STATS_EN
        check("midrst_stat_issued", 64'(o_stat_issued_r), 64'd0);
`endif
        rst = 1'b0;
        idle(12);
        check("post_rst_busy", 64'(o_busy_r), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/v_upd_issue.md
Name: v_upd_issue

Overview:
- Issue stage directly upstream of the list-update pipeline; sole driver of its List Update Bus (vld/prod_id/cmd/key/size).
- Buffers incoming update commands in an in-order FIFO with a valid/ready handshake.
- Issues the head entry only when its prod_id has no read-modify-write in flight in the issue register or pipeline stages S1..S4, which avoids stale reads from the per-product state table.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_cmd_vld  in  1  command offered
- i_cmd_prod_id  in  v_pkg::id_t  product id
- i_cmd_cmd  in  v_pkg::cmd_t  command opcode
- i_cmd_key  in  v_pkg::key_t  price key
- i_cmd_size  in  v_pkg::size_t  quantity
- o_cmd_rdy  out  1  FIFO can accept this cycle
- i_s1_upd_vld_r / i_s1_upd_prod_id_r … i_s4_upd_vld_r / i_s4_upd_prod_id_r  in  1 / v_pkg::id_t  occupancy of pipeline stages S1..S4
- o_upd_vld_r  out  1  update issued into S1
- o_upd_prod_id_r  out  v_pkg::id_t  issued product id
- o_upd_cmd_r  out  v_pkg::cmd_t  issued command
- o_upd_key_r  out  v_pkg::key_t  issued key
- o_upd_size_r  out  v_pkg::size_t  issued size
- o_busy_r  out  1  FIFO non-empty or o_upd_vld_r set

Behaviour:
- Push: when i_cmd_vld && o_cmd_rdy, the entry is written at wr_ptr and wr_ptr advances, wrapping at DEPTH.
- o_cmd_rdy = (count != DEPTH). It is a function of registered count only, with no combinational path from pop. At count == DEPTH, no push occurs even if a pop happens in the same cycle.
- Count is PTR_W+1 bits. Count changes as follows:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- Empty FIFO: a pushed entry is visible at the head next cycle. There is no bypass, so minimum latency from i_cmd_vld to o_upd_vld_r is 2 cycles.
- Hazard: the head is blocked if its prod_id equals the prod_id of any valid one of the following, an unrolled 5-way compare:
  - o_upd_vld_r/o_upd_prod_id_r
  - i_sN_upd_vld_r/i_sN_upd_prod_id_r, N = 1..4
- Pop/issue: when count != 0 and no hazard, the head is popped, rd_ptr advances, and the head fields load into the o_upd_*_r registers with o_upd_vld_r = 1 the next cycle. Otherwise o_upd_vld_r = 0 next cycle.
- o_upd_*_r data fields load only on issue; they hold their value otherwise.
- Strict in-order: a blocked head blocks all younger entries, including those for other prod_ids.
- Throughput: back-to-back issue of distinct prod_ids, 1 per cycle. Same prod_id re-issue spacing is 6 cycles (issue register + S1..S4 must drain).
- Reset, including mid-operation:
  - count = 0, wr_ptr = rd_ptr = 0
  - o_upd_vld_r = 0, o_busy_r = 0, o_cmd_rdy = 1 on the first post-reset cycle
  - FIFO contents are discarded
  - o_upd data fields and FIFO storage are not reset
- o_busy_r is the registered (count_next != 0) || issue_next.

Optional Feature:
- Macro: V_UPD_ISSUE_STATS_EN.
- When defined, adds these output ports:
  - o_stat_issued_r (32b): increments on each issue.
  - o_stat_stall_r (32b): increments each cycle count != 0 and the head is hazard-blocked.
  - o_stat_full_r (32b): increments each cycle i_cmd_vld && !o_cmd_rdy.
- All three counters wrap modulo 2^32 and reset to 0.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- v_pkg additions:
  - upd_cmd_t packed struct {id_t prod_id; cmd_t cmd; key_t key; size_t size;} used as the FIFO entry type
  - UPD_PIPE_STAGES = 4 constant, used to size the hazard compare
- Sub-module v_upd_issue_fifo: generic DEPTH x upd_cmd_t storage plus pointers, count, full/empty, with push/pop strobes and head data out. Hazard and issue logic stay in v_upd_issue.

Test Plan:
- Reset, then push prod_id 1..3 one per cycle with no stage valid -> o_upd_vld_r high 2 cycles after the first push for 3 consecutive cycles, ids 1,2,3, with cmd/key/size intact.
- Push prod_id 5 twice back-to-back -> the first issues at T; the second issues at T+6; o_upd_vld_r is low T+1..T+5.
- Hold i_s3_upd_vld_r = 1, i_s3_upd_prod_id_r = 7, push 7 then 9 -> no issue while held (9 blocked behind 7). Drop s3 valid -> 7 issues, then 9 the next cycle.
- Force a hazard on head id 2 and push DEPTH = 8 entries -> o_cmd_rdy falls after the 8th push. A 9th push is refused with the FIFO unchanged. Release the hazard -> o_cmd_rdy is high the cycle after the first issue.
- Push 4 entries, assert rst for 1 cycle mid-issue -> o_upd_vld_r = 0, o_busy_r = 0, o_cmd_rdy = 1 next cycle, and no stale entry issues afterwards.
- With V_UPD_ISSUE_STATS_EN: the prod_id 5 scenario -> o_stat_issued_r = 2, o_stat_stall_r = 5.
